// File: rtl/div_pkg.sv
// Shared types, constants and helpers for the seq_divider radix-2 restoring divider.
// Optional feature macro: SEQ_DIVIDER_SIGNED_EN (signed DIV/REM support).
package div_pkg;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned CNT_W = $clog2(WIDTH);

  // RISC-V divide-by-zero quotient
  localparam logic [WIDTH-1:0] DIV_ZERO_Q = {WIDTH{1'b1}};
  // Most negative signed value, the only dividend that can overflow
  localparam logic [WIDTH-1:0] SIGN_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Two's-complement negate when neg is set; gives magnitude when neg is the sign bit
  function automatic logic [WIDTH-1:0] neg_if(input logic [WIDTH-1:0] v, input logic neg);
    neg_if = neg ? WIDTH'((~v) + WIDTH'(1)) : v;
  endfunction

endpackage

// File: rtl/div_sub_step.sv
// One restoring-division step: trial subtract of the divisor from the shifted remainder.
module div_sub_step
  import div_pkg::*;
(
  input  logic [WIDTH:0]   shifted,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   rem_next,
  output logic             q_bit
);

  logic [WIDTH:0] diff;

  // Bit WIDTH of the difference is the borrow: set means the trial went negative
  always_comb begin
    diff     = shifted - {1'b0, divisor};
    q_bit    = ~diff[WIDTH];
    rem_next = q_bit ? diff : shifted;
  end

endmodule

// File: rtl/seq_divider.sv
// Iterative radix-2 restoring divider (RV32M DIV/DIVU/REM/REMU), one quotient bit per cycle.
// Optional feature macro: SEQ_DIVIDER_SIGNED_EN (signed mode, magnitude conversion,
// sign fixup and the signed overflow special case). Undefined: all operations unsigned.
module seq_divider
  import div_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  state_t           state_q, state_nxt;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] rem_q;   // partial remainder (top bit of the WIDTH+1 value is always 0 here)
  logic [WIDTH-1:0] dvd_q;   // dividend bits shift out at the top, quotient bits shift in at the bottom
  logic [WIDTH-1:0] dvs_q;
  logic             neg_q_q;
  logic             neg_r_q;

  logic             sgn_c;
  logic             ovf_c;
  logic             dz_c;
  logic [WIDTH:0]   shifted_c;
  logic [WIDTH:0]   step_rem_c;
  logic             step_q_c;
  logic [WIDTH-1:0] q_raw_c;
  logic             in_ready_nxt;
  logic             out_valid_nxt;
  logic             unused_bits;

`ifdef SEQ_DIVIDER_SIGNED_EN
  assign sgn_c = is_signed;
  assign ovf_c = is_signed && (dividend == SIGN_MIN) && (divisor == {WIDTH{1'b1}});
  assign unused_bits = step_rem_c[WIDTH];
`else
  assign sgn_c = 1'b0;
  assign ovf_c = 1'b0;
  assign unused_bits = ^{step_rem_c[WIDTH], is_signed};
`endif

  assign dz_c      = (divisor == '0);
  assign shifted_c = {rem_q, dvd_q[WIDTH-1]};
  assign q_raw_c   = {dvd_q[WIDTH-2:0], step_q_c};

  div_sub_step u_step (
    .shifted  (shifted_c),
    .divisor  (dvs_q),
    .rem_next (step_rem_c),
    .q_bit    (step_q_c)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state_q;
    case (state_q)
      IDLE: if (in_valid) state_nxt = (dz_c || ovf_c) ? DONE : CALC;
      CALC: if (cnt_q == '0) state_nxt = DONE;
      DONE: if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Next values of the registered handshake outputs
  always_comb begin
    in_ready_nxt  = 1'b0;
    out_valid_nxt = 1'b0;
    if (state_nxt == IDLE) in_ready_nxt  = 1'b1;
    if (state_nxt == DONE) out_valid_nxt = 1'b1;
  end

  // Datapath, counter and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      rem_q     <= '0;
      dvd_q     <= '0;
      dvs_q     <= '0;
      neg_q_q   <= 1'b0;
      neg_r_q   <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      in_ready  <= in_ready_nxt;
      out_valid <= out_valid_nxt;
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            if (dz_c) begin
              quotient  <= DIV_ZERO_Q;
              remainder <= dividend;
            end else if (ovf_c) begin
              quotient  <= dividend;
              remainder <= '0;
            end else begin
              rem_q   <= '0;
              dvd_q   <= neg_if(dividend, sgn_c & dividend[WIDTH-1]);
              dvs_q   <= neg_if(divisor, sgn_c & divisor[WIDTH-1]);
              cnt_q   <= CNT_W'(WIDTH - 1);
              neg_q_q <= sgn_c & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
              neg_r_q <= sgn_c & dividend[WIDTH-1];
            end
          end
        end
        CALC: begin
          rem_q <= step_rem_c[WIDTH-1:0];
          dvd_q <= q_raw_c;
          if (cnt_q == '0) begin
            quotient  <= neg_if(q_raw_c, neg_q_q);
            remainder <= neg_if(step_rem_c[WIDTH-1:0], neg_r_q);
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/seq_divider.md
# seq_divider

Iterative radix-2 restoring divider for the NPC execute stage. It computes quotient and remainder of two WIDTH-bit operands by repeated shift-and-subtract, one quotient bit per cycle. The block covers RV32M DIV/DIVU/REM/REMU, including RISC-V divide-by-zero and overflow results. Operands enter through a valid/ready request handshake, and results leave through a valid/ready response handshake.

## Interface
- WIDTH, 32, operand/result width in bits
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  request valid
- in_ready  out  1  block can accept a request (IDLE only)
- is_signed  in  1  1 = signed division (DIV/REM), 0 = unsigned; sampled at acceptance
- dividend  in  WIDTH  numerator, sampled at acceptance
- divisor  in  WIDTH  denominator, sampled at acceptance
- out_valid  out  1  result valid
- out_ready  in  1  consumer takes result
- quotient  out  WIDTH  quotient result
- remainder  out  WIDTH  remainder result

## Operation
- States: IDLE, CALC, DONE.
- IDLE: in_ready=1. A request is accepted on in_valid&&in_ready; the operands and the signed flag are latched.
  - divisor==0: go to DONE with quotient=all-ones and remainder=dividend, in both signed and unsigned modes.
  - Signed, dividend==1<<(WIDTH-1), divisor==all-ones: go to DONE with quotient=dividend and remainder=0.
  - Otherwise: load |dividend| and |divisor| (magnitudes in signed mode, raw values in unsigned mode), set step counter=WIDTH-1, and go to CALC.
- CALC, one step per cycle:
  - Partial remainder is WIDTH+1 bits. Shift it left, bringing in the next dividend MSB.
  - Compute a (WIDTH+1)-bit trial subtract of the divisor.
  - If the trial result is non-negative, keep it and set quotient bit=1; otherwise restore and set quotient bit=0.
  - When counter==0, apply sign fixup and go to DONE. In signed mode, negate the quotient if the operand signs differ, and give the remainder the sign of the dividend (two's complement, wraps mod 2^WIDTH).
- DONE: out_valid=1, with quotient and remainder held stable until out_ready. On out_valid&&out_ready, go to IDLE.
- in_ready=0 in CALC and DONE. A request cannot be accepted in the same cycle a result is consumed.
- In CALC and DONE, input operand changes are ignored.

## Timing
- Reset: state=IDLE, in_ready=1, out_valid=0, quotient=0, remainder=0, counter=0.
- Normal latency: if accepted at cycle T, out_valid is first high at T+WIDTH+1 (33 for WIDTH=32).
- Special-case latency (divide-by-zero, overflow): out_valid at T+1.
- Back-to-back throughput: one result per WIDTH+2 cycles with out_ready tied high.
- Reset mid-CALC or mid-DONE: the result is discarded. The next cycle shows in_ready=1, out_valid=0, and outputs=0.
- Outputs come directly from registers. There is no combinational path from in_* to out_*.

## Configuration
- SEQ_DIVIDER_SIGNED_EN defined: signed mode, magnitude conversion, sign fixup and the overflow special case are all built.
- SEQ_DIVIDER_SIGNED_EN undefined: is_signed is ignored and every operation is unsigned. The overflow check is absent, and the divide-by-zero result is unchanged.

## Structure
- Package div_pkg holds:
  - the state enum (IDLE/CALC/DONE)
  - the DIV_ZERO_Q constant (all-ones)
  - a helper function for two's-complement magnitude/negate
- One sub-module, div_sub_step. It is combinational: it takes the (WIDTH+1)-bit shifted remainder and the divisor, and returns the next remainder and the quotient bit. The top level holds the FSM, counter and registers.

## Test plan
- Unsigned 100 / 7: accepted at cycle T, then out_valid at T+33 with quotient=14 and remainder=2.
- Signed -7 / 2 (0xFFFFFFF9 / 2): quotient=0xFFFFFFFD (-3), remainder=0xFFFFFFFF (-1). Signed 7 / -2: quotient=-3, remainder=1.
- Divide by zero, 5 / 0, both modes: out_valid at T+1 with quotient=0xFFFFFFFF and remainder=5.
- Signed overflow, 0x80000000 / 0xFFFFFFFF: out_valid at T+1 with quotient=0x80000000 and remainder=0. The same operands in unsigned mode give quotient=0, remainder=0x80000000 after 33 cycles.
- Backpressure: hold out_ready=0 for 5 cycles in DONE. out_valid stays 1, outputs stay stable, and in_ready stays 0. Release, then confirm IDLE the next cycle.
- Reset at cycle T+10 during CALC: next cycle shows in_ready=1, out_valid=0, outputs=0. A new request 20/3 afterwards gives quotient=6 and remainder=2.
